// File: rtl/adc_capture_pkg.sv
// Shared conversion-mode encodings and parameter range limits for the ADC capture block.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    FMT_PASS      = 2'b00,
    FMT_OB2TC     = 2'b01,
    FMT_OB2TC_NEG = 2'b10,
    FMT_RSVD      = 2'b11
  } fmt_e;

  localparam int unsigned WIDTH_MIN = 8;
  localparam int unsigned WIDTH_MAX = 16;
  localparam int unsigned NCH_MIN   = 1;
  localparam int unsigned NCH_MAX   = 8;
  localparam int unsigned PIPE_MIN  = 0;
  localparam int unsigned PIPE_MAX  = 3;
  localparam int unsigned CNTW_MIN  = 1;
  localparam int unsigned CNTW_MAX  = 32;

endpackage

// File: rtl/adc_chan_conv.sv
// Per-channel format conversion register plus sticky overrange flag and saturating counter.
module adc_chan_conv
  import adc_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cap_word,
  input  logic             cap_valid,
  input  logic [1:0]       cap_fmt,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] conv_word,
  output logic             ovr_flag,
  output logic [CNTW-1:0]  ovr_cnt
);

  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMIN     = MSB_MASK;
  localparam logic [WIDTH-1:0] SMAX     = ~MSB_MASK;
  localparam logic [CNTW-1:0]  CNT_MAX  = {CNTW{1'b1}};

  logic [WIDTH-1:0] flip_c;
  logic [WIDTH-1:0] conv_c;
  logic             event_c;

  // Convert the captured word with its own captured mode; flag signed extremes after the flip.
  always_comb begin
    flip_c  = cap_word;
    conv_c  = cap_word;
    case (fmt_e'(cap_fmt))
      FMT_OB2TC: begin
        flip_c = cap_word ^ MSB_MASK;
        conv_c = flip_c;
      end
      FMT_OB2TC_NEG: begin
        flip_c = cap_word ^ MSB_MASK;
        conv_c = (flip_c == SMIN) ? SMAX : WIDTH'(WIDTH'(0) - flip_c);
      end
      default: begin
        flip_c = cap_word;
        conv_c = cap_word;
      end
    endcase
    event_c = cap_valid && ((flip_c == SMIN) || (flip_c == SMAX));
  end

  // Conversion register only advances on valid samples so the output holds between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_word <= '0;
    end else if (cap_valid) begin
      conv_word <= conv_c;
    end
  end

  // Overrange status; a clear in the same cycle as an event discards the event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_flag <= 1'b0;
      ovr_cnt  <= '0;
    end else if (ovr_clr) begin
      ovr_flag <= 1'b0;
      ovr_cnt  <= '0;
    end else if (event_c) begin
      ovr_flag <= 1'b1;
      if (ovr_cnt != CNT_MAX) begin
        ovr_cnt <= ovr_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_data_capture.sv
// Multi-channel ADC capture: input register, per-channel conversion, optional output pipeline.
module adc_data_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned NCH   = 2,
  parameter int unsigned PIPE  = 0,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*WIDTH-1:0]  din,
  input  logic                  din_valid,
  input  logic [1:0]            fmt_sel,
  input  logic                  ovr_clr,
  output logic [NCH*WIDTH-1:0]  dout,
  output logic                  dout_valid,
  output logic [NCH-1:0]        ovr_flag,
  output logic [NCH*CNTW-1:0]   ovr_cnt
);

  localparam int unsigned DW = NCH * WIDTH;

  (* IOB = "TRUE" *) logic [DW-1:0] cap_din;
  logic          cap_valid;
  logic [1:0]    cap_fmt;
  logic [DW-1:0] conv_data;
  logic          conv_valid;

  // Capture stage: data, qualifier and mode registered together every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_din   <= '0;
      cap_valid <= 1'b0;
      cap_fmt   <= 2'b00;
    end else begin
      cap_din   <= din;
      cap_valid <= din_valid;
      cap_fmt   <= fmt_sel;
    end
  end

  // Valid qualifier aligned with the conversion registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_valid <= 1'b0;
    end else begin
      conv_valid <= cap_valid;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    adc_chan_conv #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_conv (
      .clk       (clk),
      .rst_n     (rst_n),
      .cap_word  (cap_din[k*WIDTH +: WIDTH]),
      .cap_valid (cap_valid),
      .cap_fmt   (cap_fmt),
      .ovr_clr   (ovr_clr),
      .conv_word (conv_data[k*WIDTH +: WIDTH]),
      .ovr_flag  (ovr_flag[k]),
      .ovr_cnt   (ovr_cnt[k*CNTW +: CNTW])
    );
  end

  if (PIPE == 0) begin : g_nopipe
    assign dout       = conv_data;
    assign dout_valid = conv_valid;
  end else begin : g_pipe
    localparam int unsigned PDW = PIPE * DW;

    logic [PIPE-1:0][DW-1:0] pipe_data;
    logic [PIPE-1:0]         pipe_valid;
    logic [PIPE-1:0][DW-1:0] data_src;
    logic [PIPE-1:0]         valid_src;

    assign data_src  = PDW'({pipe_data, conv_data});
    assign valid_src = PIPE'({pipe_valid, conv_valid});

    // Delay line; each stage only loads when the sample entering it is valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_data  <= '0;
        pipe_valid <= '0;
      end else begin
        pipe_valid <= valid_src;
        for (int i = 0; i < int'(PIPE); i++) begin
          if (valid_src[i]) begin
            pipe_data[i] <= data_src[i];
          end
        end
      end
    end

    assign dout       = pipe_data[PIPE-1];
    assign dout_valid = pipe_valid[PIPE-1];
  end

endmodule

// File: tb/tb_adc_data_capture.sv
// Directed bench: 4-channel PIPE=0 CNTW=4 instance plus 2-channel PIPE=3 instance on shared controls.
module tb_adc_data_capture;

  localparam int W = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4*W-1:0] din;
  logic          din_valid;
  logic [1:0]    fmt_sel;
  logic          ovr_clr;

  logic [4*W-1:0] dout0;
  logic           dv0;
  logic [3:0]     flag0;
  logic [15:0]    cnt0;

  logic [2*W-1:0] dout1;
  logic           dv1;
  logic [1:0]     flag1;
  logic [31:0]    cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adc_data_capture #(.WIDTH(13), .NCH(4), .PIPE(0), .CNTW(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fmt_sel(fmt_sel),
    .ovr_clr(ovr_clr), .dout(dout0), .dout_valid(dv0), .ovr_flag(flag0), .ovr_cnt(cnt0)
  );

  adc_data_capture #(.WIDTH(13), .NCH(2), .PIPE(3), .CNTW(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din[2*W-1:0]), .din_valid(din_valid), .fmt_sel(fmt_sel),
    .ovr_clr(ovr_clr), .dout(dout1), .dout_valid(dv1), .ovr_flag(flag1), .ovr_cnt(cnt1)
  );

  function automatic logic [4*W-1:0] pk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] f, input logic [4*W-1:0] d);
    din_valid = v;
    fmt_sel   = f;
    din       = d;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    ovr_clr   = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_ovr;
    din_valid = 1'b0;
    ovr_clr   = 1'b1;
    tick();
    ovr_clr   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = '0; din_valid = 1'b0; fmt_sel = 2'b00; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dout0 !== '0) begin n_bad++; $display("FAIL rst_dout0 got %h exp 0", dout0); end
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL rst_dv0 got %b exp 0", dv0); end
    n_cmp++; if (flag0 !== 4'h0) begin n_bad++; $display("FAIL rst_flag0 got %h exp 0", flag0); end
    n_cmp++; if (cnt0 !== 16'h0) begin n_bad++; $display("FAIL rst_cnt0 got %h exp 0", cnt0); end
    n_cmp++; if (dout1 !== '0) begin n_bad++; $display("FAIL rst_dout1 got %h exp 0", dout1); end
    n_cmp++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL rst_dv1 got %b exp 0", dv1); end
    n_cmp++; if ({flag1, cnt1} !== 34'h0) begin n_bad++; $display("FAIL rst_ovr1 got %h/%h exp 0", flag1, cnt1); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({dv0, dv1} !== 2'b00) begin n_bad++; $display("FAIL rst_rel_dv got %b exp 00", {dv0, dv1}); end
  endtask

  task automatic test_mode01;
    logic [W-1:0] r0 [3];
    logic [W-1:0] e0 [3];
    r0 = '{13'h0000, 13'h1000, 13'h1FFF};
    e0 = '{13'h1000, 13'h0000, 13'h0FFF};
    idle(6); clear_ovr(); idle(2);
    for (int c = 0; c < 4; c++) begin
      if (c < 3) set_in(1'b1, 2'b01, pk(r0[c], 13'h0800, 13'h0ABC, 13'h1555));
      else       set_in(1'b0, 2'b01, '0);
      tick();
      if (c == 0) begin
        n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL m01_early_valid got %b exp 0", dv0); end
      end else begin
        n_cmp++;
        if (dout0 !== pk(e0[c-1], 13'h1800, 13'h1ABC, 13'h0555)) begin
          n_bad++; $display("FAIL m01_dout c=%0d got %h exp %h", c, dout0, pk(e0[c-1], 13'h1800, 13'h1ABC, 13'h0555));
        end
        n_cmp++; if (dv0 !== 1'b1) begin n_bad++; $display("FAIL m01_valid c=%0d got %b exp 1", c, dv0); end
      end
    end
    tick();
    n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL m01_idle_valid got %b exp 0", dv0); end
    n_cmp++; if (dout0[W-1:0] !== 13'h0FFF) begin n_bad++; $display("FAIL m01_hold got %h exp 0fff", dout0[W-1:0]); end
    n_cmp++; if (cnt0 !== 16'h0002) begin n_bad++; $display("FAIL m01_cnt got %h exp 0002", cnt0); end
    n_cmp++; if (flag0 !== 4'b0001) begin n_bad++; $display("FAIL m01_flag got %b exp 0001", flag0); end
  endtask

  task automatic test_mode10;
    logic [W-1:0] r0 [3];
    logic [W-1:0] e0 [3];
    r0 = '{13'h0000, 13'h1FFF, 13'h1000};
    e0 = '{13'h0FFF, 13'h1001, 13'h0000};
    idle(6); clear_ovr(); idle(2);
    for (int c = 0; c < 4; c++) begin
      if (c < 3) set_in(1'b1, 2'b10, pk(r0[c], 13'h0001, 13'h0FFF, 13'h1800));
      else       set_in(1'b0, 2'b10, '0);
      tick();
      if (c > 0) begin
        n_cmp++;
        if (dout0 !== pk(e0[c-1], 13'h0FFF, 13'h0001, 13'h1800)) begin
          n_bad++; $display("FAIL m10_dout c=%0d got %h exp %h", c, dout0, pk(e0[c-1], 13'h0FFF, 13'h0001, 13'h1800));
        end
      end
    end
    n_cmp++; if (cnt0 !== 16'h0002) begin n_bad++; $display("FAIL m10_cnt got %h exp 0002", cnt0); end
    n_cmp++; if (flag0 !== 4'b0001) begin n_bad++; $display("FAIL m10_flag got %b exp 0001", flag0); end
  endtask

  task automatic test_mode_switch;
    logic [W-1:0] e [6];
    int i0, i1;
    e = '{13'h0100, 13'h0101, 13'h0102, 13'h1103, 13'h1104, 13'h1105};
    idle(6);
    for (int c = 0; c < 11; c++) begin
      if (c < 6) set_in(1'b1, (c < 3) ? 2'b00 : 2'b01, pk(W'(13'h0100 + c), 13'h0400, 13'h0400, 13'h0400));
      else       set_in(1'b0, 2'b01, '0);
      tick();
      i0 = c - 1;
      i1 = c - 4;
      if (i0 >= 0 && i0 < 6) begin
        n_cmp++; if (dv0 !== 1'b1) begin n_bad++; $display("FAIL sw_dv0 c=%0d got %b exp 1", c, dv0); end
        n_cmp++; if (dout0[W-1:0] !== e[i0]) begin n_bad++; $display("FAIL sw_dout0 c=%0d got %h exp %h", c, dout0[W-1:0], e[i0]); end
      end else begin
        n_cmp++; if (dv0 !== 1'b0) begin n_bad++; $display("FAIL sw_dv0 c=%0d got %b exp 0", c, dv0); end
      end
      if (i1 >= 0 && i1 < 6) begin
        n_cmp++; if (dv1 !== 1'b1) begin n_bad++; $display("FAIL sw_dv1 c=%0d got %b exp 1", c, dv1); end
        n_cmp++; if (dout1[W-1:0] !== e[i1]) begin n_bad++; $display("FAIL sw_dout1 c=%0d got %h exp %h", c, dout1[W-1:0], e[i1]); end
      end else begin
        n_cmp++; if (dv1 !== 1'b0) begin n_bad++; $display("FAIL sw_dv1 c=%0d got %b exp 0", c, dv1); end
      end
    end
  endtask

  task automatic test_saturation;
    idle(6); clear_ovr(); idle(1);
    for (int c = 0; c < 20; c++) begin
      set_in(1'b1, 2'b01, pk(13'h0000, 13'h0800, 13'h0800, 13'h0800));
      tick();
    end
    idle(2);
    n_cmp++; if (cnt0 !== 16'h000F) begin n_bad++; $display("FAIL sat_cnt0 got %h exp 000f", cnt0); end
    n_cmp++; if (flag0 !== 4'b0001) begin n_bad++; $display("FAIL sat_flag0 got %b exp 0001", flag0); end
    n_cmp++; if (cnt1[15:0] !== 16'd20) begin n_bad++; $display("FAIL sat_cnt1 got %0d exp 20", cnt1[15:0]); end
    set_in(1'b1, 2'b01, pk(13'h0000, 13'h0800, 13'h0800, 13'h0800));
    tick();
    din_valid = 1'b0;
    ovr_clr   = 1'b1;
    tick();
    n_cmp++; if ({flag0, cnt0} !== 20'h0) begin n_bad++; $display("FAIL clr_win got %b/%h exp 0/0", flag0, cnt0); end
    ovr_clr = 1'b0;
    tick();
    n_cmp++; if ({flag0, cnt0} !== 20'h0) begin n_bad++; $display("FAIL clr_after got %b/%h exp 0/0", flag0, cnt0); end
  endtask

  task automatic test_channels;
    logic [4*W-1:0] ex [8];
    logic [W-1:0]   r  [4];
    idle(6); clear_ovr(); idle(1);
    for (int c = 0; c < 9; c++) begin
      if (c < 8) begin
        r[0] = W'($urandom_range(13'h1FFE, 1));
        r[1] = W'($urandom_range(13'h1FFE, 1));
        r[2] = (c % 2 == 0) ? 13'h0000 : 13'h1FFF;
        r[3] = W'($urandom_range(13'h1FFE, 1));
        ex[c] = pk(r[0] ^ 13'h1000, r[1] ^ 13'h1000, r[2] ^ 13'h1000, r[3] ^ 13'h1000);
        set_in(1'b1, 2'b01, pk(r[0], r[1], r[2], r[3]));
      end else begin
        set_in(1'b0, 2'b01, '0);
      end
      tick();
      if (c > 0) begin
        n_cmp++; if (dout0 !== ex[c-1]) begin n_bad++; $display("FAIL ch_dout c=%0d got %h exp %h", c, dout0, ex[c-1]); end
      end
    end
    n_cmp++; if (flag0 !== 4'b0100) begin n_bad++; $display("FAIL ch_flag got %b exp 0100", flag0); end
    n_cmp++; if (cnt0 !== 16'h0800) begin n_bad++; $display("FAIL ch_cnt got %h exp 0800", cnt0); end
  endtask

  task automatic test_reset_midstream;
    idle(6);
    for (int c = 0; c < 3; c++) begin
      set_in(1'b1, 2'b01, pk(13'h0000, 13'h0000, 13'h0000, 13'h0000));
      tick();
    end
    n_cmp++; if ({dv0, flag0} !== 5'b1_1111) begin n_bad++; $display("FAIL mid_pre got %b/%b exp 1/1111", dv0, flag0); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({dout0, dv0, flag0, cnt0} !== '0) begin n_bad++; $display("FAIL mid_rst0 got %h/%b/%b/%h exp 0", dout0, dv0, flag0, cnt0); end
    n_cmp++; if ({dout1, dv1, flag1, cnt1} !== '0) begin n_bad++; $display("FAIL mid_rst1 got %h/%b/%b/%h exp 0", dout1, dv1, flag1, cnt1); end
    tick();
    tick();
    din_valid = 1'b0;
    rst_n     = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++; if ({dv0, dv1} !== 2'b00) begin n_bad++; $display("FAIL mid_flush c=%0d got %b exp 00", c, {dv0, dv1}); end
    end
    set_in(1'b1, 2'b01, pk(13'h0123, 13'h0123, 13'h0123, 13'h0123));
    for (int c = 0; c < 7; c++) begin
      tick();
      din_valid = 1'b0;
      n_cmp++; if (dv0 !== (c == 1)) begin n_bad++; $display("FAIL mid_lat0 c=%0d got %b exp %b", c, dv0, (c == 1)); end
      n_cmp++; if (dv1 !== (c == 4)) begin n_bad++; $display("FAIL mid_lat1 c=%0d got %b exp %b", c, dv1, (c == 4)); end
      if (c == 1) begin
        n_cmp++; if (dout0[W-1:0] !== 13'h1123) begin n_bad++; $display("FAIL mid_dout0 got %h exp 1123", dout0[W-1:0]); end
      end
      if (c == 4) begin
        n_cmp++; if (dout1[W-1:0] !== 13'h1123) begin n_bad++; $display("FAIL mid_dout1 got %h exp 1123", dout1[W-1:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode01();
    test_mode10();
    test_mode_switch();
    test_saturation();
    test_channels();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_data_capture.md
ADC_DATA_CAPTURE -- requirements
Module: adc_data_capture

Interface
REQ-001 Parameter WIDTH, default 13, sample width in bits (range 8..16).
REQ-002 Parameter NCH, default 2, number of parallel ADC channels (range 1..8).
REQ-003 Parameter PIPE, default 0, extra pipeline stages between conversion and output (range 0..3).
REQ-004 Parameter CNTW, default 16, width of the per-channel overrange counters.
REQ-005 Port clk, input, 1, sole clock; every register in the block is clocked on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port din, input, NCH*WIDTH, raw ADC words; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port din_valid, input, 1, din qualifier for the current cycle.
REQ-009 Port fmt_sel, input, 2, conversion mode: 00 pass-through, 01 offset-binary to two's complement (MSB flip), 10 MSB flip followed by saturating negate, 11 reserved and treated as 00.
REQ-010 Port ovr_clr, input, 1, synchronous clear pulse for all overrange counters and flags.
REQ-011 Port dout, output, NCH*WIDTH, converted signed samples, packed the same way as din.
REQ-012 Port dout_valid, output, 1, dout qualifier.
REQ-013 Port ovr_flag, output, NCH, sticky per-channel overrange flags.
REQ-014 Port ovr_cnt, output, NCH*CNTW, per-channel overrange event counts.

Function
REQ-015 Capture stage: din, din_valid and fmt_sel shall be registered together every cycle, unconditionally; din registers shall carry the IOB packing attribute.
REQ-016 Conversion stage: captured words shall be converted using the captured fmt_sel, so that a mode change is aligned to its sample and takes effect on exactly one sample boundary.
REQ-017 Mode 01: dout word = capture word XOR (1 << (WIDTH-1)).
REQ-018 Mode 10: MSB flip, then two's-complement negate; the most negative code -2^(WIDTH-1) shall map to +2^(WIDTH-1)-1.
REQ-019 Latency: din to dout, and din_valid to dout_valid, shall be exactly 2+PIPE cycles, with dout_valid tracking din_valid.
REQ-020 dout shall hold its last value while dout_valid is 0; samples with din_valid=0 shall not update dout.
REQ-021 Overrange event: a valid captured sample whose post-flip value equals the signed min or signed max for WIDTH (raw 0 or all-ones in modes 01/10; signed extremes in mode 00).
REQ-022 Each overrange event shall set ovr_flag[k] and increment ovr_cnt[k] by 1; ovr_cnt shall saturate at 2^CNTW-1 and never wrap.
REQ-023 ovr_clr shall zero all counters and flags on the next edge; if an event and ovr_clr occur in the same cycle, clear wins and the event is dropped.
REQ-024 Overrange status shall be updated in the conversion stage, 2 cycles after capture, independent of PIPE.
REQ-025 Channels shall be fully independent; no cross-channel combinational path.

Reset
REQ-026 rst_n low shall asynchronously zero all capture, pipeline and output registers, including dout, dout_valid, ovr_flag and ovr_cnt.
REQ-027 Samples in flight when rst_n asserts shall be discarded; dout_valid shall be 0 until 2+PIPE cycles after the first valid din following rst_n release.

Structure
REQ-028 Mode encodings (FMT_PASS, FMT_OB2TC, FMT_OB2TC_NEG) and the WIDTH/NCH/PIPE/CNTW range limits shall live in a shared package, adc_capture_pkg.
REQ-029 The per-channel conversion and overrange logic shall be one sub-module, adc_chan_conv, instantiated NCH times with a generate loop; the top level owns capture, the valid pipeline and output packing.

Verification
REQ-030 WIDTH=13, mode 01, din_valid=1, ch0 raw 0x0000/0x1000/0x1FFF -> dout ch0 = -4096/0/+4095 exactly 2 cycles later (PIPE=0).
REQ-031 Mode 10, raw 0x0000 -> dout +4095 (saturated); raw 0x1FFF -> -4095; ovr_cnt[0] increments for both samples.
REQ-032 fmt_sel toggles 00->01 on sample N -> samples <N unconverted and samples >=N converted, with no mixed sample; repeat with PIPE=3 and check latency is 5.
REQ-033 CNTW=4, 20 consecutive overrange samples -> ovr_cnt stays at 15; ovr_clr asserted in the same cycle as an event -> count 0, flag 0.
REQ-034 Assert rst_n low mid-stream with a valid burst in the pipeline -> all outputs 0 immediately; first dout_valid occurs 2+PIPE cycles after the first post-reset din_valid.
REQ-035 NCH=4, overrange on ch2 only -> only ovr_flag[2] sets; all other channels' dout are bit-exact against the reference model.
